// File: rtl/backprop_sequencer.sv
// Backpropagation sequencer: stores one sample's forward-pass activations, then issues one
// backpropagator start per layer, from the top layer down to layer 0.
module backprop_sequencer #(
  parameter int NEURON_NUM          = 5,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int LAYER_ADDR_WIDTH    = 2,
  parameter int LAYER_MAX           = 3,
  parameter int SAMPLE_ADDR_SIZE    = 10,
  parameter int TIMEOUT             = 1023
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [SAMPLE_ADDR_SIZE-1:0]               sample,
  input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] z_in,
  input  logic [LAYER_ADDR_WIDTH:0]                 z_in_addr,
  input  logic                                      z_in_valid,
  output logic                                      z_in_ready,
  output logic                                      bp_start,
  output logic [LAYER_ADDR_WIDTH-1:0]               bp_layer,
  output logic [SAMPLE_ADDR_SIZE-1:0]               bp_sample,
  output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] bp_z,
  output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] bp_z_prev,
  input  logic                                      bp_valid,
  input  logic                                      bp_error,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      error
);

  localparam int ZW  = NEURON_NUM * NEURON_OUTPUT_WIDTH;
  localparam int AW  = LAYER_ADDR_WIDTH + 1;
  // A disabled watchdog still gets a 1-bit counter so the declaration stays legal.
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, FIN, ABORT} state_t;

  state_t           state;
  logic [ZW-1:0]    slot [LAYER_MAX+1];
  logic [LAYER_MAX:0] mask;
  logic [WDW-1:0]   watchdog;
  logic             timeout;

  assign timeout    = (TIMEOUT != 0) && (watchdog == WDW'(TIMEOUT));
  assign z_in_ready = (state == IDLE) || (state == LOAD);
  assign busy       = (state != IDLE);

  always_comb begin
    bp_z      = '0;
    bp_z_prev = '0;
    for (int unsigned i = 0; i < LAYER_MAX; i++) begin
      if (bp_layer == LAYER_ADDR_WIDTH'(i)) begin
        bp_z      = slot[i+1];
        bp_z_prev = slot[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bp_start  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      bp_layer  <= '0;
      bp_sample <= '0;
      mask      <= '0;
      watchdog  <= '0;
      for (int unsigned i = 0; i <= LAYER_MAX; i++) slot[i] <= '0;
    end else begin
      bp_start <= 1'b0;
      done     <= 1'b0;
      if (z_in_valid && z_in_ready) begin
        for (int unsigned i = 0; i <= LAYER_MAX; i++) begin
          if (z_in_addr == AW'(i)) begin
            slot[i] <= z_in;
            mask[i] <= 1'b1;
          end
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            bp_sample <= sample;
            error     <= 1'b0;
          end
        end
        LOAD: begin
          if (&mask) begin
            state    <= ISSUE;
            bp_layer <= LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
            bp_start <= 1'b1;
          end
        end
        ISSUE: begin
          watchdog <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (watchdog != '1) watchdog <= watchdog + 1'b1;
          if (bp_error || timeout) begin
            state <= ABORT;
            error <= 1'b1;
          end else if (bp_valid) begin
            if (bp_layer == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              bp_layer <= bp_layer - 1'b1;
              state    <= ISSUE;
              bp_start <= 1'b1;
            end
          end
        end
        FIN: begin
          mask  <= '0;
          state <= IDLE;
        end
        ABORT: begin
          error <= 1'b1;
          mask  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_backprop_sequencer.sv
// Directed bench for backprop_sequencer: one instance with an 8-cycle watchdog and one with
// the watchdog disabled, both driven by the same stimulus.
module tb_backprop_sequencer;

  localparam logic [49:0] JUNK = 50'h3_DEAD_BEEF_0BAD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  sample = '0;
  logic [49:0] z_in = '0;
  logic [2:0]  z_in_addr = '0;
  logic        z_in_valid = 1'b0;
  logic        bp_valid = 1'b0;
  logic        bp_error = 1'b0;

  logic        a_z_in_ready, a_bp_start, a_busy, a_done, a_error;
  logic [1:0]  a_bp_layer;
  logic [9:0]  a_bp_sample;
  logic [49:0] a_bp_z, a_bp_z_prev;
  logic        b_z_in_ready, b_bp_start, b_busy, b_done, b_error;
  logic [1:0]  b_bp_layer;
  logic [9:0]  b_bp_sample;
  logic [49:0] b_bp_z, b_bp_z_prev;

  logic [49:0] za [4];
  logic [49:0] zb [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  backprop_sequencer #(.TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sample(sample),
    .z_in(z_in), .z_in_addr(z_in_addr), .z_in_valid(z_in_valid), .z_in_ready(a_z_in_ready),
    .bp_start(a_bp_start), .bp_layer(a_bp_layer), .bp_sample(a_bp_sample),
    .bp_z(a_bp_z), .bp_z_prev(a_bp_z_prev), .bp_valid(bp_valid), .bp_error(bp_error),
    .busy(a_busy), .done(a_done), .error(a_error)
  );

  backprop_sequencer #(.TIMEOUT(0)) u_dut_nowd (
    .clk(clk), .rst(rst), .start(start), .sample(sample),
    .z_in(z_in), .z_in_addr(z_in_addr), .z_in_valid(z_in_valid), .z_in_ready(b_z_in_ready),
    .bp_start(b_bp_start), .bp_layer(b_bp_layer), .bp_sample(b_bp_sample),
    .bp_z(b_bp_z), .bp_z_prev(b_bp_z_prev), .bp_valid(bp_valid), .bp_error(bp_error),
    .busy(b_busy), .done(b_done), .error(b_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [49:0] v);
    z_in_addr  = a;
    z_in       = v;
    z_in_valid = 1'b1;
    tick();
    z_in_valid = 1'b0;
  endtask

  // Entered on the bp_start cycle; returns on the cycle after bp_valid is taken.
  task automatic run_layer(input int lay, input logic [49:0] ez, input logic [49:0] ezp,
                           input logic [9:0] es);
    check("bp_start", a_bp_start, 1);
    check("bp_layer", a_bp_layer, 64'(lay));
    check("bp_z", a_bp_z, ez);
    check("bp_z_prev", a_bp_z_prev, ezp);
    check("bp_sample", a_bp_sample, es);
    tick();
    check("bp_start_one_cycle", a_bp_start, 0);
    z_in_valid = 1'b1;
    z_in_addr  = 3'(lay + 1);
    z_in       = JUNK;
    tick();
    z_in_valid = 1'b0;
    start  = 1'b1;
    sample = 10'd99;
    tick();
    start = 1'b0;
    tick();
    check("bp_z_stable", a_bp_z, ez);
    check("bp_z_prev_stable", a_bp_z_prev, ezp);
    check("bp_sample_hold", a_bp_sample, es);
    check("busy_wait", a_busy, 1);
    check("z_in_ready_wait", a_z_in_ready, 0);
    check("no_done_wait", a_done, 0);
    bp_valid = 1'b1;
    tick();
    bp_valid = 1'b0;
    if (lay > 0) begin
      check("next_start_latency", a_bp_start, 1);
    end else begin
      check("done_pulse", a_done, 1);
      check("no_start_at_fin", a_bp_start, 0);
      tick();
      check("done_one_cycle", a_done, 0);
      check("busy_idle", a_busy, 0);
      check("ready_idle", a_z_in_ready, 1);
    end
  endtask

  initial begin
    za[0] = 50'h0_4321_8765_0F0F; za[1] = 50'h1_1234_5678_9ABC;
    za[2] = 50'h2_0F0F_F0F0_5A5A; za[3] = 50'h3_CAFE_0123_4567;
    zb[0] = 50'h0_AAAA_5555_0001; zb[1] = 50'h1_5555_AAAA_0002;
    zb[2] = 50'h2_1357_9BDF_0003; zb[3] = 50'h3_2468_ACE0_0004;

    // reset state
    repeat (2) tick();
    check("rst_busy", a_busy, 0);
    check("rst_bp_start", a_bp_start, 0);
    check("rst_done", a_done, 0);
    check("rst_error", a_error, 0);
    check("rst_bp_layer", a_bp_layer, 0);
    check("rst_bp_sample", a_bp_sample, 0);
    check("rst_ready", a_z_in_ready, 1);
    check("rst_bp_z", a_bp_z, 0);
    rst = 1'b1;
    tick();

    // nominal: full preload, three layers
    for (int i = 0; i < 4; i++) wr(3'(i), za[i]);
    start  = 1'b1;
    sample = 10'd7;
    tick();
    start = 1'b0;
    check("load_busy", a_busy, 1);
    check("load_ready", a_z_in_ready, 1);
    check("load_no_start", a_bp_start, 0);
    tick();
    run_layer(2, za[3], za[2], 10'd7);
    run_layer(1, za[2], za[1], 10'd7);
    run_layer(0, za[1], za[0], 10'd7);

    // partial preload, out-of-range address, last write one cycle after start
    wr(3'd0, zb[0]);
    wr(3'd4, JUNK);
    wr(3'd1, zb[1]);
    start      = 1'b1;
    sample     = 10'd3;
    z_in_valid = 1'b1;
    z_in_addr  = 3'd2;
    z_in       = zb[2];
    tick();
    start     = 1'b0;
    z_in_addr = 3'd3;
    z_in      = zb[3];
    tick();
    z_in_valid = 1'b0;
    check("partial_no_early_start", a_bp_start, 0);
    tick();
    run_layer(2, zb[3], zb[2], 10'd3);
    run_layer(1, zb[2], zb[1], 10'd3);
    run_layer(0, zb[1], zb[0], 10'd3);

    // bp_error together with bp_valid at layer 1
    for (int i = 0; i < 4; i++) wr(3'(i), za[i]);
    start  = 1'b1;
    sample = 10'd5;
    tick();
    start = 1'b0;
    tick();
    run_layer(2, za[3], za[2], 10'd5);
    check("abort_layer", a_bp_layer, 1);
    tick();
    tick();
    bp_valid = 1'b1;
    bp_error = 1'b1;
    tick();
    bp_valid = 1'b0;
    bp_error = 1'b0;
    check("abort_error", a_error, 1);
    check("abort_no_done", a_done, 0);
    check("abort_no_start", a_bp_start, 0);
    tick();
    check("abort_sticky", a_error, 1);
    check("abort_idle", a_busy, 0);
    check("abort_no_done2", a_done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_quiet", a_bp_start, 0);
    end
    start  = 1'b1;
    sample = 10'd6;
    tick();
    start = 1'b0;
    check("restart_clears_error", a_error, 0);
    check("restart_busy", a_busy, 1);
    repeat (4) tick();
    check("reload_required", a_bp_start, 0);
    check("reload_waiting", a_z_in_ready, 1);
    for (int i = 0; i < 4; i++) wr(3'(i), zb[i]);
    tick();
    check("reload_start", a_bp_start, 1);
    check("reload_layer", a_bp_layer, 2);
    check("reload_sample", a_bp_sample, 6);

    // watchdog: no bp_valid ever
    repeat (9) tick();
    check("wd_not_yet", a_error, 0);
    check("wd_busy", a_busy, 1);
    tick();
    check("wd_error", a_error, 1);
    check("wd_no_done", a_done, 0);
    check("nowd_error", b_error, 0);
    check("nowd_busy", b_busy, 1);
    repeat (40) tick();
    check("nowd_still_busy", b_busy, 1);
    check("nowd_still_no_error", b_error, 0);
    check("nowd_no_start", b_bp_start, 0);
    check("wd_error_sticky", a_error, 1);
    check("wd_idle", a_busy, 0);

    // asynchronous reset mid-WAIT
    #2 rst = 1'b0;
    #1;
    check("arst_busy", b_busy, 0);
    check("arst_bp_start", b_bp_start, 0);
    check("arst_done", b_done, 0);
    check("arst_error", b_error, 0);
    check("arst_layer", b_bp_layer, 0);
    check("arst_slots", b_bp_z, 0);
    check("arst_error_a", a_error, 0);
    #3 rst = 1'b1;
    tick();
    check("post_rst_ready", b_z_in_ready, 1);
    check("post_rst_ready_a", a_z_in_ready, 1);
    check("post_rst_idle", b_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
